// File: rtl/issue_buffer.sv
// Issue buffer: circular queue that accepts up to ISSUE_NUM instructions per cycle
// and offers the oldest ISSUE_NUM entries, in program order, to the issue stage.
module issue_buffer #(
  parameter int ISSUE_NUM = 1,
  parameter int DEPTH     = 8,
  parameter int INST_W    = 32,
  parameter int PC_W      = 64,
  localparam int CW = $clog2(ISSUE_NUM + 1),
  localparam int NW = $clog2(DEPTH + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [CW-1:0]               in_cnt,
  input  logic [ISSUE_NUM*INST_W-1:0] in_inst,
  input  logic [ISSUE_NUM*PC_W-1:0]   in_pc,
  output logic [ISSUE_NUM-1:0]        out_valid,
  output logic [ISSUE_NUM*INST_W-1:0] out_inst,
  output logic [ISSUE_NUM*PC_W-1:0]   out_pc,
  input  logic [CW-1:0]               out_accept,
  input  logic                        flush,
  output logic [NW-1:0]               count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [NW-1:0] READY_MAX = NW'(DEPTH - ISSUE_NUM);

  logic [INST_W-1:0] inst_mem_q [DEPTH];
  logic [INST_W-1:0] inst_mem_d [DEPTH];
  logic [PC_W-1:0]   pc_mem_q   [DEPTH];
  logic [PC_W-1:0]   pc_mem_d   [DEPTH];
  logic [AW-1:0]     head_q, head_d;
  logic [AW-1:0]     tail_q, tail_d;
  logic [NW-1:0]     count_q, count_d;
  logic [CW-1:0]     push_cnt, pop_cnt, avail_cnt;
  logic              push;

  // Readiness looks at the registered count only, so a full buffer stays
  // closed for one cycle even when the consumer drains it in the same cycle.
  assign in_ready = (count_q <= READY_MAX);
  assign count    = count_q;

  always_comb begin
    push_cnt = in_cnt;
    if (int'(in_cnt) > ISSUE_NUM) push_cnt = CW'(ISSUE_NUM);
    push = in_valid & in_ready & ~flush & (in_cnt != '0);
    avail_cnt = CW'(ISSUE_NUM);
    if (int'(count_q) < ISSUE_NUM) avail_cnt = CW'(count_q);
    pop_cnt = (out_accept < avail_cnt) ? out_accept : avail_cnt;
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + AW'(pop_cnt);
      if (push) tail_d = tail_q + AW'(push_cnt);
      count_d = count_q + (push ? NW'(push_cnt) : '0) - NW'(pop_cnt);
    end
  end

  // Pointer arithmetic wraps naturally because DEPTH is a power of two.
  always_comb begin
    inst_mem_d = inst_mem_q;
    pc_mem_d   = pc_mem_q;
    for (int i = 0; i < ISSUE_NUM; i++) begin
      if (push && (i < int'(push_cnt))) begin
        inst_mem_d[tail_q + AW'(i)] = in_inst[i*INST_W +: INST_W];
        pc_mem_d[tail_q + AW'(i)]   = in_pc[i*PC_W +: PC_W];
      end
    end
  end

  always_comb begin
    out_valid = '0;
    out_inst  = '0;
    out_pc    = '0;
    for (int i = 0; i < ISSUE_NUM; i++) begin
      out_valid[i]                 = (int'(count_q) > i);
      out_inst[i*INST_W +: INST_W] = inst_mem_q[head_q + AW'(i)];
      out_pc[i*PC_W +: PC_W]       = pc_mem_q[head_q + AW'(i)];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage carries no reset; stale slots are masked by out_valid.
  always_ff @(posedge clk) begin
    inst_mem_q <= inst_mem_d;
    pc_mem_q   <= pc_mem_d;
  end

endmodule

// File: tb/tb_issue_buffer.sv
// Bench for issue_buffer: four instances (2/4, 1/8, 3/8, 4/8) checked one at a
// time against a queue model of the buffer contents.
module tb_issue_buffer;

  localparam int NI = 4;
  localparam int N_TAB [NI] = '{2, 1, 3, 4};
  localparam int D_TAB [NI] = '{4, 8, 8, 8};

  typedef struct packed {
    logic [31:0] inst;
    logic [63:0] pc;
  } ent_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         flush;
  logic         in_valid_a [NI];
  logic [2:0]   in_cnt_a   [NI];
  logic [127:0] in_inst_a  [NI];
  logic [255:0] in_pc_a    [NI];
  logic [2:0]   acc_a      [NI];
  logic         in_ready_a [NI];
  logic [3:0]   ov_a       [NI];
  logic [127:0] oi_a       [NI];
  logic [255:0] op_a       [NI];
  logic [3:0]   cnt_a      [NI];

  ent_t sb[$];
  int   next_tag = 0;
  int   nchk = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int N  = N_TAB[g];
    localparam int D  = D_TAB[g];
    localparam int CW = $clog2(N + 1);
    localparam int NW = $clog2(D + 1);
    logic [CW-1:0]   u_in_cnt, u_acc;
    logic [N-1:0]    u_ov;
    logic [N*32-1:0] u_oi;
    logic [N*64-1:0] u_op;
    logic [NW-1:0]   u_cnt;
    assign u_in_cnt = in_cnt_a[g][CW-1:0];
    assign u_acc    = acc_a[g][CW-1:0];
    issue_buffer #(.ISSUE_NUM(N), .DEPTH(D), .INST_W(32), .PC_W(64)) u_dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid_a[g]), .in_ready(in_ready_a[g]), .in_cnt(u_in_cnt),
      .in_inst(in_inst_a[g][N*32-1:0]), .in_pc(in_pc_a[g][N*64-1:0]),
      .out_valid(u_ov), .out_inst(u_oi), .out_pc(u_op),
      .out_accept(u_acc), .flush(flush), .count(u_cnt)
    );
    assign ov_a[g]  = 4'(u_ov);
    assign oi_a[g]  = 128'(u_oi);
    assign op_a[g]  = 256'(u_op);
    assign cnt_a[g] = 4'(u_cnt);
  end

  function automatic logic [31:0] tinst(input int t);
    return 32'hA000_0000 + 32'(t);
  endfunction

  function automatic logic [63:0] tpc(input int t);
    return 64'h100 + 64'(4 * t);
  endfunction

  function automatic logic [3:0] therm(input int sz, input int n);
    logic [3:0] m;
    m = '0;
    for (int i = 0; i < n; i++) if (i < sz) m[i] = 1'b1;
    return m;
  endfunction

  task automatic set_group(input int k, input logic v, input int cnt);
    in_valid_a[k] = v;
    in_cnt_a[k]   = 3'(cnt);
    for (int i = 0; i < 4; i++) begin
      in_inst_a[k][i*32 +: 32] = tinst(next_tag + i);
      in_pc_a[k][i*64 +: 64]   = tpc(next_tag + i);
    end
  endtask

  // Advance one clock and update the reference queue with the same rules the
  // buffer must follow; called at the falling edge, returns at the next one.
  task automatic tick(input int k);
    int   n, d, sz, avail, pop, pcnt;
    bit   pushok;
    ent_t tmp [4];
    ent_t dump;
    n = N_TAB[k];
    d = D_TAB[k];
    sz = sb.size();
    avail = (sz < n) ? sz : n;
    pop = int'(acc_a[k]);
    if (pop > avail) pop = avail;
    pcnt = int'(in_cnt_a[k]);
    if (pcnt > n) pcnt = n;
    pushok = in_valid_a[k] && (d - sz >= n) && !flush && (pcnt != 0);
    for (int i = 0; i < 4; i++) tmp[i] = {in_inst_a[k][i*32 +: 32], in_pc_a[k][i*64 +: 64]};
    @(posedge clk);
    if (flush) begin
      sb.delete();
    end else begin
      for (int i = 0; i < pop; i++) dump = sb.pop_front();
      if (pushok) begin
        for (int i = 0; i < pcnt; i++) sb.push_back(tmp[i]);
        next_tag += pcnt;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    #1;
    for (int k = 0; k < NI; k++) begin
      nchk++;
      if (cnt_a[k] !== 4'd0) begin
        nerr++; $display("FAIL reset_count k=%0d got %0d want 0", k, cnt_a[k]);
      end
      nchk++;
      if (ov_a[k] !== 4'b0000) begin
        nerr++; $display("FAIL reset_out_valid k=%0d got %b want 0000", k, ov_a[k]);
      end
      nchk++;
      if (in_ready_a[k] !== 1'b1) begin
        nerr++; $display("FAIL reset_in_ready k=%0d got %b want 1", k, in_ready_a[k]);
      end
    end
    @(negedge clk);
    rst = 1'b1;
    sb.delete();
  endtask

  task automatic test_push_basic(input int k);
    int n, t0;
    n = N_TAB[k];
    t0 = next_tag;
    set_group(k, 1'b1, n);
    acc_a[k] = 3'd0;
    nchk++;
    if (ov_a[k] !== 4'b0000) begin
      nerr++; $display("FAIL push_no_bypass k=%0d got %b want 0000", k, ov_a[k]);
    end
    tick(k);
    in_valid_a[k] = 1'b0;
    nchk++;
    if (ov_a[k] !== therm(n, n)) begin
      nerr++; $display("FAIL push_out_valid k=%0d got %b want %b", k, ov_a[k], therm(n, n));
    end
    nchk++;
    if (cnt_a[k] !== 4'(n)) begin
      nerr++; $display("FAIL push_count k=%0d got %0d want %0d", k, cnt_a[k], n);
    end
    for (int i = 0; i < n; i++) begin
      nchk++;
      if (oi_a[k][i*32 +: 32] !== tinst(t0 + i) || op_a[k][i*64 +: 64] !== tpc(t0 + i)) begin
        nerr++;
        $display("FAIL push_slot%0d k=%0d got %h/%h want %h/%h", i, k,
                 oi_a[k][i*32 +: 32], op_a[k][i*64 +: 64], tinst(t0 + i), tpc(t0 + i));
      end
    end
    acc_a[k] = 3'(n);
    tick(k);
    acc_a[k] = 3'd0;
    nchk++;
    if (cnt_a[k] !== 4'd0) begin
      nerr++; $display("FAIL push_drain k=%0d got %0d want 0", k, cnt_a[k]);
    end
  endtask

  task automatic test_fill();
    int t0;
    t0 = next_tag;
    set_group(0, 1'b1, 2);
    tick(0);
    set_group(0, 1'b1, 2);
    tick(0);
    nchk++;
    if (cnt_a[0] !== 4'd4 || in_ready_a[0] !== 1'b0) begin
      nerr++; $display("FAIL fill_full got count=%0d rdy=%b want 4/0", cnt_a[0], in_ready_a[0]);
    end
    set_group(0, 1'b1, 2);
    tick(0);
    nchk++;
    if (cnt_a[0] !== 4'd4) begin
      nerr++; $display("FAIL fill_held got %0d want 4", cnt_a[0]);
    end
    acc_a[0] = 3'd1;
    tick(0);
    nchk++;
    if (cnt_a[0] !== 4'd3 || in_ready_a[0] !== 1'b0) begin
      nerr++; $display("FAIL fill_acc1 got count=%0d rdy=%b want 3/0", cnt_a[0], in_ready_a[0]);
    end
    tick(0);
    nchk++;
    if (cnt_a[0] !== 4'd2 || in_ready_a[0] !== 1'b1) begin
      nerr++; $display("FAIL fill_acc2 got count=%0d rdy=%b want 2/1", cnt_a[0], in_ready_a[0]);
    end
    for (int i = 0; i < 2; i++) begin
      nchk++;
      if (oi_a[0][i*32 +: 32] !== tinst(t0 + 2 + i)) begin
        nerr++; $display("FAIL fill_slot%0d got %h want %h", i, oi_a[0][i*32 +: 32], tinst(t0 + 2 + i));
      end
    end
    in_valid_a[0] = 1'b0;
    acc_a[0] = 3'd2;
    tick(0);
    acc_a[0] = 3'd0;
    nchk++;
    if (cnt_a[0] !== 4'd0) begin
      nerr++; $display("FAIL fill_drain got %0d want 0", cnt_a[0]);
    end
  endtask

  task automatic test_wrap(input int k);
    int pat [4] = '{1, 2, 1, 2};
    int n, d, cnt, sz;
    n = N_TAB[k];
    d = D_TAB[k];
    for (int c = 0; c < 10; c++) begin
      cnt = (pat[c % 4] > n) ? n : pat[c % 4];
      set_group(k, 1'b1, cnt);
      acc_a[k] = (c % 2 == 1) ? 3'((n < 2) ? n : 2) : 3'd0;
      sz = sb.size();
      nchk++;
      if (ov_a[k] !== therm(sz, n) || cnt_a[k] !== 4'(sz) || in_ready_a[k] !== (d - sz >= n)) begin
        nerr++;
        $display("FAIL wrap_state k=%0d c=%0d got ov=%b cnt=%0d rdy=%b want ov=%b cnt=%0d",
                 k, c, ov_a[k], cnt_a[k], in_ready_a[k], therm(sz, n), sz);
      end
      for (int i = 0; i < n; i++) begin
        if (i < sz) begin
          nchk++;
          if (oi_a[k][i*32 +: 32] !== sb[i].inst || op_a[k][i*64 +: 64] !== sb[i].pc) begin
            nerr++;
            $display("FAIL wrap_order k=%0d c=%0d slot%0d got %h/%h want %h/%h", k, c, i,
                     oi_a[k][i*32 +: 32], op_a[k][i*64 +: 64], sb[i].inst, sb[i].pc);
          end
        end
      end
      tick(k);
    end
    in_valid_a[k] = 1'b0;
    acc_a[k] = 3'(n);
    for (int j = 0; j < 8 && sb.size() > 0; j++) tick(k);
    set_group(k, 1'b1, 1);
    acc_a[k] = 3'd0;
    tick(k);
    in_valid_a[k] = 1'b0;
    nchk++;
    if (cnt_a[k] !== 4'd1) begin
      nerr++; $display("FAIL sat_setup k=%0d got %0d want 1", k, cnt_a[k]);
    end
    acc_a[k] = 3'(n);
    tick(k);
    acc_a[k] = 3'd0;
    nchk++;
    if (cnt_a[k] !== 4'd0 || ov_a[k] !== 4'b0000) begin
      nerr++; $display("FAIL sat_pop k=%0d got cnt=%0d ov=%b want 0/0000", k, cnt_a[k], ov_a[k]);
    end
  endtask

  task automatic test_clamp();
    int t0;
    t0 = next_tag;
    set_group(0, 1'b1, 3);
    tick(0);
    nchk++;
    if (cnt_a[0] !== 4'd2 || oi_a[0][31:0] !== tinst(t0) || oi_a[0][63:32] !== tinst(t0 + 1)) begin
      nerr++; $display("FAIL clamp got cnt=%0d s0=%h s1=%h want 2/%h/%h",
                       cnt_a[0], oi_a[0][31:0], oi_a[0][63:32], tinst(t0), tinst(t0 + 1));
    end
    set_group(0, 1'b1, 0);
    tick(0);
    nchk++;
    if (cnt_a[0] !== 4'd2) begin
      nerr++; $display("FAIL cnt_zero got %0d want 2", cnt_a[0]);
    end
    in_valid_a[0] = 1'b0;
    acc_a[0] = 3'd2;
    tick(0);
    acc_a[0] = 3'd0;
  endtask

  task automatic test_simul();
    int t0;
    t0 = next_tag;
    set_group(0, 1'b1, 2);
    tick(0);
    set_group(0, 1'b1, 2);
    acc_a[0] = 3'd2;
    tick(0);
    in_valid_a[0] = 1'b0;
    acc_a[0] = 3'd0;
    nchk++;
    if (cnt_a[0] !== 4'd2) begin
      nerr++; $display("FAIL simul_count got %0d want 2", cnt_a[0]);
    end
    for (int i = 0; i < 2; i++) begin
      nchk++;
      if (oi_a[0][i*32 +: 32] !== tinst(t0 + 2 + i) || op_a[0][i*64 +: 64] !== tpc(t0 + 2 + i)) begin
        nerr++; $display("FAIL simul_slot%0d got %h/%h want %h/%h", i, oi_a[0][i*32 +: 32],
                         op_a[0][i*64 +: 64], tinst(t0 + 2 + i), tpc(t0 + 2 + i));
      end
    end
    set_group(0, 1'b1, 2);
    acc_a[0] = 3'd2;
    flush = 1'b1;
    tick(0);
    flush = 1'b0;
    in_valid_a[0] = 1'b0;
    acc_a[0] = 3'd0;
    nchk++;
    if (cnt_a[0] !== 4'd0 || ov_a[0] !== 4'b0000 || in_ready_a[0] !== 1'b1) begin
      nerr++; $display("FAIL flush got cnt=%0d ov=%b rdy=%b want 0/0000/1", cnt_a[0], ov_a[0], in_ready_a[0]);
    end
  endtask

  task automatic test_reset_mid();
    int t0;
    set_group(0, 1'b1, 2);
    tick(0);
    set_group(0, 1'b1, 1);
    tick(0);
    in_valid_a[0] = 1'b0;
    nchk++;
    if (cnt_a[0] !== 4'd3) begin
      nerr++; $display("FAIL rmid_setup got %0d want 3", cnt_a[0]);
    end
    #2 rst = 1'b0;
    #1;
    nchk++;
    if (cnt_a[0] !== 4'd0 || ov_a[0] !== 4'b0000 || in_ready_a[0] !== 1'b1) begin
      nerr++; $display("FAIL rmid_async got cnt=%0d ov=%b rdy=%b want 0/0000/1", cnt_a[0], ov_a[0], in_ready_a[0]);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    sb.delete();
    t0 = next_tag;
    set_group(0, 1'b1, 2);
    tick(0);
    in_valid_a[0] = 1'b0;
    nchk++;
    if (ov_a[0] !== 4'b0011 || cnt_a[0] !== 4'd2 || oi_a[0][31:0] !== tinst(t0) || oi_a[0][63:32] !== tinst(t0 + 1)) begin
      nerr++; $display("FAIL rmid_after got ov=%b cnt=%0d s0=%h s1=%h want 0011/2/%h/%h",
                       ov_a[0], cnt_a[0], oi_a[0][31:0], oi_a[0][63:32], tinst(t0), tinst(t0 + 1));
    end
    acc_a[0] = 3'd2;
    tick(0);
    acc_a[0] = 3'd0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    flush = 1'b0;
    for (int k = 0; k < NI; k++) begin
      in_valid_a[k] = 1'b0;
      in_cnt_a[k]   = 3'd0;
      in_inst_a[k]  = '0;
      in_pc_a[k]    = '0;
      acc_a[k]      = 3'd0;
    end
    test_reset();
    test_push_basic(0);
    test_fill();
    test_wrap(0);
    test_clamp();
    test_simul();
    test_reset_mid();
    for (int k = 1; k < NI; k++) begin
      test_push_basic(k);
      test_wrap(k);
    end
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/issue_buffer.md
ISSUE_BUFFER -- requirements
Module: issue_buffer

Interface
REQ-001 Parameter ISSUE_NUM, default 1, issue width; instructions enqueued and offered per cycle; legal values 1..4.
REQ-002 Parameter DEPTH, default 8, entry count; power of two; DEPTH >= 2*ISSUE_NUM.
REQ-003 Parameter INST_W, default 32, instruction width.
REQ-004 Parameter PC_W, default 64, PC width.
REQ-005 CW denotes clog2(ISSUE_NUM+1); NW denotes clog2(DEPTH+1).
REQ-006 clk  in  1  single clock; all state updates on the rising edge.
REQ-007 rst  in  1  asynchronous, active-low reset.
REQ-008 in_valid  in  1  an instruction group is presented.
REQ-009 in_ready  out  1  the buffer can accept a full group this cycle.
REQ-010 in_cnt  in  CW  instructions in the group, 1..ISSUE_NUM; occupies slots 0..in_cnt-1.
REQ-011 in_inst  in  ISSUE_NUM*INST_W  group instructions; slot 0 in the LSBs and oldest in program order.
REQ-012 in_pc  in  ISSUE_NUM*PC_W  group PCs, packed the same way as in_inst.
REQ-013 out_valid  out  ISSUE_NUM  thermometer mask of offered slots; bit 0 is the oldest entry.
REQ-014 out_inst  out  ISSUE_NUM*INST_W  offered instructions, packed as in_inst.
REQ-015 out_pc  out  ISSUE_NUM*PC_W  offered PCs.
REQ-016 out_accept  in  CW  number of offered slots consumed this cycle, oldest first.
REQ-017 flush  in  1  discards all entries, e.g. on branch mispredict or trap.
REQ-018 count  out  NW  current occupancy.

Function
REQ-019 Storage is a circular buffer with head, tail and count registers; pointers wrap modulo DEPTH.
REQ-020 in_ready = (DEPTH - count) >= ISSUE_NUM, computed from the current count only; no same-cycle pop credit.
REQ-021 push = in_valid & in_ready & ~flush & (in_cnt != 0); a push writes in_cnt entries at tail..tail+in_cnt-1 (mod DEPTH), and tail advances by in_cnt.
REQ-022 in_cnt > ISSUE_NUM is clamped to ISSUE_NUM; in_cnt == 0 writes nothing.
REQ-023 out_valid[i] = (count > i); slot i presents the entry at head+i (mod DEPTH); out data is don't-care where out_valid[i] = 0.
REQ-024 pop = min(out_accept, popcount(out_valid)) when flush = 0; head advances by pop.
REQ-025 count_next = count + pushed - popped; simultaneous push and pop is legal in every state.
REQ-026 Latency: an entry written at edge N is offered from cycle N+1; there is no input-to-output bypass.
REQ-027 Outputs are driven from registers and the count only; no combinational path from in_* or out_accept to out_*.
REQ-028 flush = 1 at edge N: head = tail = count = 0 after edge N; flush overrides push and pop in the same cycle.
REQ-029 When in_valid = 1 and in_ready = 0, nothing is written; the producer holds the group.
REQ-030 Program order is preserved across wrap-around and partial groups (in_cnt < ISSUE_NUM).

Reset
REQ-031 rst low asynchronously sets head = tail = count = 0, out_valid = 0 and in_ready = 1, independent of clk.
REQ-032 Reset asserted mid-operation discards all entries; the first push after release behaves as from an empty buffer.
REQ-033 Storage contents are not reset; they are never visible while out_valid is 0.

Verification (ISSUE_NUM=2, DEPTH=4, unless noted)
REQ-034 Reset: rst low with no clock edge -> count = 0, out_valid = 2'b00, in_ready = 1.
REQ-035 Push {cnt=2, A@0x100, B@0x104} at edge 0 -> cycle 1: out_valid = 2'b11, slot0 = A/0x100, slot1 = B/0x104, count = 2.
REQ-036 Fill: push 2 + push 2 -> count = 4, in_ready = 0, a held group is not written. out_accept = 1 -> count = 3, in_ready still 0. out_accept = 1 again -> count = 2, in_ready = 1.
REQ-037 Wrap and partial groups: pushes of cnt 1,2,1,2 interleaved with accept 2 over 10 cycles -> output order matches push order exactly. out_accept = 2 with count = 1 -> pop saturates to 1, count = 0.
REQ-038 Simultaneous events: count = 2, push 2 (C,D) + accept 2 -> count = 2, next cycle slot0 = C, slot1 = D. flush together with push and accept -> count = 0, out_valid = 0.
REQ-039 Parameter sweep: repeat REQ-035 and REQ-037 for ISSUE_NUM = 1, 3, 4 with DEPTH = 8, checked against a reference queue model.
